// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with iterative shift-add multiply and restoring divide.
// Define ALU_ITER_DIV_EN to build the divu/remu datapath; otherwise those codes return 0.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam int SH = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
`ifdef ALU_ITER_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op;
  logic [WIDTH-1:0] hi, lo, bv;
  logic [WIDTH-1:0] hi_n, lo_n, bv_n;
  logic [WIDTH-1:0] alu_y, iter_y;
  logic [SH-1:0]    sh;
  logic             iter_op;

  assign Zero = (Result == '0);
  assign sh   = SrcB[SH-1:0];

`ifdef ALU_ITER_DIV_EN
  assign iter_op = (ALUControl == OP_MUL) ||
                   (ALUControl == OP_DIVU) ||
                   (ALUControl == OP_REMU);
`else
  assign iter_op = (ALUControl == OP_MUL);
`endif

  always_comb begin
    alu_y = '0;
    case (ALUControl)
      OP_ADD:  alu_y = SrcA + SrcB;
      OP_SUB:  alu_y = SrcA - SrcB;
      OP_AND:  alu_y = SrcA & SrcB;
      OP_OR:   alu_y = SrcA | SrcB;
      OP_XOR:  alu_y = SrcA ^ SrcB;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}},
                        $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      OP_SLL:  alu_y = SrcA << sh;
      OP_SRL:  alu_y = SrcA >> sh;
      OP_SRA:  alu_y = WIDTH'($signed(SrcA) >>> sh);
      default: alu_y = '0;
    endcase
  end

  // hi = accumulator/remainder, lo = multiplier/quotient, bv = multiplicand/divisor
`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0] r2;
  logic [WIDTH:0] rd;
`endif

  always_comb begin
    hi_n   = hi;
    lo_n   = lo;
    bv_n   = bv;
    iter_y = '0;
`ifdef ALU_ITER_DIV_EN
    r2 = {hi, lo[WIDTH-1]};
    rd = r2 - {1'b0, bv};
`endif
    if (op == OP_MUL) begin
      hi_n   = lo[0] ? hi + bv : hi;
      lo_n   = lo >> 1;
      bv_n   = bv << 1;
      iter_y = hi_n;
    end
`ifdef ALU_ITER_DIV_EN
    else begin
      if (r2 >= {1'b0, bv}) begin
        hi_n = rd[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = r2[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
      iter_y = (op == OP_DIVU) ? lo_n : hi_n;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      Result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      op     <= '0;
      hi     <= '0;
      lo     <= '0;
      bv     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            op <= ALUControl;
            if (iter_op) begin
              state <= ITER;
              busy  <= 1'b1;
              cnt   <= CW'(WIDTH);
              hi    <= '0;
              lo    <= SrcA;
              bv    <= SrcB;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              Result <= alu_y;
            end
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          hi  <= hi_n;
          lo  <= lo_n;
          bv  <= bv_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            Result <= iter_y;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
